// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : csr_pkg
//  Description : Shared definitions for the machine-mode CSR write unit:
//                CSR addresses, funct3 operation encodings and
//                mcountinhibit bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

  // Writable machine-mode CSRs
  localparam logic [11:0] c_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] c_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] c_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] c_ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] c_ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] c_ADDR_MINSTRETH     = 12'hB82;

  // Read-only user shadows of the machine counters
  localparam logic [11:0] c_ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] c_ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] c_ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] c_ADDR_INSTRETH      = 12'hC82;

  // Upper nibble of the read-only CSR window
  localparam logic [3:0]  c_RO_NIBBLE          = 4'hC;

  // funct3 encodings of the SYSTEM/CSR instructions
  typedef enum logic [2:0] {
    CSR_OP_RSV0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RSV4 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  // mcountinhibit bit positions
  localparam int c_MCI_CY = 0;
  localparam int c_MCI_IR = 2;

endpackage : csr_pkg
`default_nettype wire

// File: rtl/csr_write_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : csr_write_unit_if
//  Description : EX-stage CSR request/response bundle between the pipeline
//                (master) and the CSR write unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_write_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  csr_valid_i;
  logic [2:0]            csr_op_i;
  logic [11:0]           csr_addr_i;
  logic [4:0]            rs1_addr_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic                  retire_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  illegal_o;

  // Pipeline side: issues the CSR instruction, consumes old value / trap flag
  modport master (
    output csr_valid_i, csr_op_i, csr_addr_i, rs1_addr_i, rs1_data_i, retire_i,
    input  csr_rdata_o, illegal_o
  );

  // CSR unit side
  modport slave (
    input  csr_valid_i, csr_op_i, csr_addr_i, rs1_addr_i, rs1_data_i, retire_i,
    output csr_rdata_o, illegal_o
  );

endinterface : csr_write_unit_if
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : Wide event counter written one DATA_WIDTH half at a time.
//                Any half-write takes priority over, and suppresses, the
//                increment for that cycle; the untouched half holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_WIDTH  = 64
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_ni,
  input  wire logic                  i_inc,
  input  wire logic                  i_wr_lo,
  input  wire logic                  i_wr_hi,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  output logic      [CSR_WIDTH-1:0]  o_value
);

  localparam logic [CSR_WIDTH-1:0] c_ONE = {{(CSR_WIDTH-1){1'b0}}, 1'b1};

  logic [CSR_WIDTH-1:0] r_value;

  // Half-writes win over the increment; full-width add carries across halves
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_value <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_value[DATA_WIDTH-1:0]         <= i_wdata;
      if (i_wr_hi) r_value[CSR_WIDTH-1:DATA_WIDTH] <= i_wdata;
    end else if (i_inc) begin
      r_value <= r_value + c_ONE;
    end
  end

  assign o_value = r_value;

endmodule : csr_counter64
`default_nettype wire

// File: rtl/csr_write_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_write_unit
//  Description : Machine-mode CSR read/write/read-modify-write unit for
//                CSRRW/RS/RC and immediate forms. Holds mcycle, minstret,
//                mscratch and (optionally) mcountinhibit; serves the
//                read-only cycle/instret shadows. Reads are combinational.
//  Config      : define CSR_COUNTINHIBIT_EN to implement mcountinhibit
//                (CY bit 0, IR bit 2). Otherwise 0x320 reads 0 and writes
//                to it are silently dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_write_unit
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_WIDTH  = 64
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  csr_write_unit_if.slave   csr_bus
);

  csr_op_e                w_op;
  logic                   w_is_imm;
  logic                   w_op_rsv;
  logic [DATA_WIDTH-1:0]  w_src;
  logic                   w_wr_req;
  logic                   w_mapped;
  logic [DATA_WIDTH-1:0]  w_old;
  logic [DATA_WIDTH-1:0]  w_new;
  logic                   w_illegal;
  logic                   w_wr;
  logic [CSR_WIDTH-1:0]   w_mcycle;
  logic [CSR_WIDTH-1:0]   w_minstret;
  logic [DATA_WIDTH-1:0]  w_mcountinhibit;
  logic [DATA_WIDTH-1:0]  r_mscratch;

  assign w_op     = csr_op_e'(csr_bus.csr_op_i);
  assign w_is_imm = csr_bus.csr_op_i[2];
  assign w_op_rsv = (w_op == CSR_OP_RSV0) || (w_op == CSR_OP_RSV4);

  // Immediate forms take the rs1 field as a zero-extended 5-bit operand
  assign w_src = w_is_imm ? {{(DATA_WIDTH-5){1'b0}}, csr_bus.rs1_addr_i}
                          : csr_bus.rs1_data_i;

  // Set/clear with x0 (or zimm 0) is a pure read; swaps always write
  assign w_wr_req = (w_op == CSR_OP_RW) || (w_op == CSR_OP_RWI) ||
                    (csr_bus.rs1_addr_i != 5'd0);

  // Address decode and old-value select from current register state
  always_comb begin
    w_mapped = 1'b1;
    w_old    = '0;
    case (csr_bus.csr_addr_i)
      c_ADDR_MSCRATCH:                   w_old = r_mscratch;
      c_ADDR_MCOUNTINHIBIT:              w_old = w_mcountinhibit;
      c_ADDR_MCYCLE,    c_ADDR_CYCLE:    w_old = w_mcycle[DATA_WIDTH-1:0];
      c_ADDR_MCYCLEH,   c_ADDR_CYCLEH:   w_old = w_mcycle[CSR_WIDTH-1:DATA_WIDTH];
      c_ADDR_MINSTRET,  c_ADDR_INSTRET:  w_old = w_minstret[DATA_WIDTH-1:0];
      c_ADDR_MINSTRETH, c_ADDR_INSTRETH: w_old = w_minstret[CSR_WIDTH-1:DATA_WIDTH];
      default:                           w_mapped = 1'b0;
    endcase
  end

  // New value for swap / set / clear; reserved encodings leave it unchanged
  always_comb begin
    w_new = w_old;
    case (w_op)
      CSR_OP_RW, CSR_OP_RWI: w_new = w_src;
      CSR_OP_RS, CSR_OP_RSI: w_new = w_old | w_src;
      CSR_OP_RC, CSR_OP_RCI: w_new = w_old & ~w_src;
      default:               w_new = w_old;
    endcase
  end

  assign w_illegal = csr_bus.csr_valid_i &&
                     (!w_mapped || w_op_rsv ||
                      (w_wr_req && (csr_bus.csr_addr_i[11:8] == c_RO_NIBBLE)));

  assign w_wr = csr_bus.csr_valid_i && !w_illegal && w_wr_req;

  assign csr_bus.csr_rdata_o = (csr_bus.csr_valid_i && !w_illegal) ? w_old : '0;
  assign csr_bus.illegal_o   = w_illegal;

  // Per-CSR write strobes
  logic w_wr_mscratch, w_wr_mcountinhibit;
  logic w_wr_mcycle_lo, w_wr_mcycle_hi, w_wr_minstret_lo, w_wr_minstret_hi;

  assign w_wr_mscratch      = w_wr && (csr_bus.csr_addr_i == c_ADDR_MSCRATCH);
  assign w_wr_mcountinhibit = w_wr && (csr_bus.csr_addr_i == c_ADDR_MCOUNTINHIBIT);
  assign w_wr_mcycle_lo     = w_wr && (csr_bus.csr_addr_i == c_ADDR_MCYCLE);
  assign w_wr_mcycle_hi     = w_wr && (csr_bus.csr_addr_i == c_ADDR_MCYCLEH);
  assign w_wr_minstret_lo   = w_wr && (csr_bus.csr_addr_i == c_ADDR_MINSTRET);
  assign w_wr_minstret_hi   = w_wr && (csr_bus.csr_addr_i == c_ADDR_MINSTRETH);

  // mscratch: plain scratch register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mscratch <= '0;
    else if (w_wr_mscratch) r_mscratch <= w_new;
  end

`ifdef CSR_COUNTINHIBIT_EN
  logic [DATA_WIDTH-1:0] r_mcountinhibit;
  logic [DATA_WIDTH-1:0] w_mci_mask;

  assign w_mci_mask = (DATA_WIDTH'(1) << c_MCI_CY) | (DATA_WIDTH'(1) << c_MCI_IR);

  // mcountinhibit: only CY and IR are storage bits, the rest read as zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mcountinhibit <= '0;
    else if (w_wr_mcountinhibit) r_mcountinhibit <= w_new & w_mci_mask;
  end

  assign w_mcountinhibit = r_mcountinhibit;
`else
  logic w_unused_mci_wr;
  assign w_unused_mci_wr = w_wr_mcountinhibit;
  assign w_mcountinhibit = '0;
`endif

  logic w_inc_cycle, w_inc_instret;
  assign w_inc_cycle   = !w_mcountinhibit[c_MCI_CY];
  assign w_inc_instret = csr_bus.retire_i && !w_mcountinhibit[c_MCI_IR];

  csr_counter64 #(
    .DATA_WIDTH (DATA_WIDTH),
    .CSR_WIDTH  (CSR_WIDTH)
  ) u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_inc   (w_inc_cycle),
    .i_wr_lo (w_wr_mcycle_lo),
    .i_wr_hi (w_wr_mcycle_hi),
    .i_wdata (w_new),
    .o_value (w_mcycle)
  );

  csr_counter64 #(
    .DATA_WIDTH (DATA_WIDTH),
    .CSR_WIDTH  (CSR_WIDTH)
  ) u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_inc   (w_inc_instret),
    .i_wr_lo (w_wr_minstret_lo),
    .i_wr_hi (w_wr_minstret_hi),
    .i_wdata (w_new),
    .o_value (w_minstret)
  );

endmodule : csr_write_unit
`default_nettype wire

// File: tb/tb_csr_write_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_write_unit
//  Description : Directed scoreboard bench for csr_write_unit. Each issued
//                CSR instruction pushes its hand-computed old value and
//                illegal flag; a negedge monitor pops and compares. Define
//                CSR_COUNTINHIBIT_EN to exercise the mcountinhibit build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_write_unit;

  localparam logic [2:0] OP_RSV = 3'b000;
  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic done;
  int   n_assert;
  int   n_fail;
  exp_t exp_q[$];
  exp_t e;

  csr_write_unit_if #(.DATA_WIDTH(32)) bus ();

  csr_write_unit #(
    .DATA_WIDTH (32),
    .CSR_WIDTH  (64)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .csr_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: end of test not reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  // One instruction per cycle; expected response queued before it is driven
  task automatic issue(input string nm, input logic [2:0] op, input logic [11:0] addr,
                       input logic [4:0] ra, input logic [31:0] rd, input logic ret,
                       input logic [31:0] exp_d, input logic exp_i);
    exp_q.push_back('{name: nm, rdata: exp_d, ill: exp_i});
    bus.csr_valid_i = 1'b1;
    bus.csr_op_i    = op;
    bus.csr_addr_i  = addr;
    bus.rs1_addr_i  = ra;
    bus.rs1_data_i  = rd;
    bus.retire_i    = ret;
    @(posedge clk);
    #1;
    bus.csr_valid_i = 1'b0;
    bus.csr_op_i    = 3'b000;
    bus.csr_addr_i  = 12'h000;
    bus.rs1_addr_i  = 5'd0;
    bus.rs1_data_i  = 32'h0;
    bus.retire_i    = 1'b0;
  endtask

  // Monitor: scoreboard compare on valid, zero-output check when idle
  always @(negedge clk) begin
    if (done) begin
      n_assert = n_assert + 1;
      if (exp_q.size() != 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
    end else if (bus.csr_valid_i) begin
      n_assert = n_assert + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_response: rdata=%h illegal=%b, required no response",
                 bus.csr_rdata_o, bus.illegal_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.csr_rdata_o !== e.rdata || bus.illegal_o !== e.ill) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: rdata=%h illegal=%b, required rdata=%h illegal=%b",
                   e.name, bus.csr_rdata_o, bus.illegal_o, e.rdata, e.ill);
        end
      end
    end else begin
      n_assert = n_assert + 1;
      if (bus.csr_rdata_o !== 32'h0 || bus.illegal_o !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL idle_outputs: rdata=%h illegal=%b, required rdata=0 illegal=0",
                 bus.csr_rdata_o, bus.illegal_o);
      end
    end
  end

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    done            = 1'b0;
    rst_n           = 1'b0;
    bus.csr_valid_i = 1'b0;
    bus.csr_op_i    = 3'b000;
    bus.csr_addr_i  = 12'h000;
    bus.rs1_addr_i  = 5'd0;
    bus.rs1_data_i  = 32'h0;
    bus.retire_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    issue("rst_mcycle",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("rst_mscratch", OP_RS, 12'h340, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Ten free-running cycles
    repeat (10) @(posedge clk);
    #1;
    issue("idle10_lo", OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'd10, 1'b0);
    issue("idle10_hi", OP_RS, 12'hB80, 5'd0, 32'h0, 1'b0, 32'd0,  1'b0);

    // Carry from low half into high half, back-to-back instructions
    issue("mcycle_rw",    OP_RW, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'd12, 1'b0);
    issue("mcycle_wr_lo", OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    issue("carry_lo",     OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("carry_hi",     OP_RS, 12'hB80, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0);

    // mscratch read-modify-write forms
    issue("msc_rw",      OP_RW,  12'h340, 5'd3,    32'h0000_00FF, 1'b0, 32'h0, 1'b0);
    issue("msc_rs_x0",   OP_RS,  12'h340, 5'd0,    32'h1234_5678, 1'b0, 32'hFF, 1'b0);
    issue("msc_rci",     OP_RCI, 12'h340, 5'h05,   32'h0, 1'b0, 32'hFF, 1'b0);
    issue("msc_after_c", OP_RS,  12'h340, 5'd0,    32'h0, 1'b0, 32'hFA, 1'b0);
    issue("msc_rsi",     OP_RSI, 12'h340, 5'h05,   32'h0, 1'b0, 32'hFA, 1'b0);
    issue("msc_rw2",     OP_RW,  12'h340, 5'd4,    32'hDEAD_BEEF, 1'b0, 32'hFF, 1'b0);
    issue("msc_rwi0",    OP_RWI, 12'h340, 5'd0,    32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    issue("msc_zero",    OP_RS,  12'h340, 5'd0,    32'h0, 1'b0, 32'h0, 1'b0);

    // Illegal accesses and read-only shadows
    issue("ro_write",    OP_RW,  12'hC00, 5'd2, 32'h5, 1'b0, 32'h0, 1'b1);
    issue("ro_read_lo",  OP_RS,  12'hC00, 5'd0, 32'h0, 1'b0, 32'h0000_000B, 1'b0);
    issue("ro_read_hi",  OP_RS,  12'hC80, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0);
    issue("ro_rsi",      OP_RSI, 12'hC00, 5'd1, 32'h0, 1'b0, 32'h0, 1'b1);
    issue("rsv_funct3",  OP_RSV, 12'h340, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    issue("unmapped",    OP_RS,  12'h341, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);

    // minstret: write wins over same-cycle retire, partial high write
    issue("mi_rw_ret",   OP_RW, 12'hB02, 5'd1, 32'h100, 1'b1, 32'h0,   1'b0);
    issue("mi_after_wr", OP_RS, 12'hB02, 5'd0, 32'h0,   1'b1, 32'h100, 1'b0);
    issue("mi_retire",   OP_RS, 12'hB02, 5'd0, 32'h0,   1'b0, 32'h101, 1'b0);
    issue("instret_lo",  OP_RS, 12'hC02, 5'd0, 32'h0,   1'b0, 32'h101, 1'b0);
    issue("instret_hi",  OP_RS, 12'hC82, 5'd0, 32'h0,   1'b0, 32'h0,   1'b0);
    issue("mi_wr_hi",    OP_RW, 12'hB82, 5'd1, 32'h7,   1'b1, 32'h0,   1'b0);
    issue("mi_hi_new",   OP_RS, 12'hB82, 5'd0, 32'h0,   1'b0, 32'h7,   1'b0);
    issue("mi_lo_held",  OP_RS, 12'hB02, 5'd0, 32'h0,   1'b0, 32'h101, 1'b0);

    // Asynchronous reset mid-operation clears state before the next edge
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    issue("rst2_mcycle",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("rst2_minsth",   OP_RS, 12'hB82, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("rst2_mscratch", OP_RS, 12'h340, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;

`ifdef CSR_COUNTINHIBIT_EN
    issue("mci_wr",       OP_RW, 12'h320, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    issue("mci_rd",       OP_RS, 12'h320, 5'd0, 32'h0, 1'b0, 32'h5, 1'b0);
    issue("mi_frz0",      OP_RS, 12'hB02, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    issue("mc_frozen",    OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0);
    issue("mi_frozen",    OP_RS, 12'hB02, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    issue("mc_frz_wr",    OP_RW, 12'hB00, 5'd1, 32'h40, 1'b0, 32'h1, 1'b0);
    issue("mc_frz_new",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h40, 1'b0);
    issue("mci_clr",      OP_RW, 12'h320, 5'd1, 32'h0, 1'b0, 32'h5, 1'b0);
    issue("mc_resume0",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h40, 1'b0);
    issue("mc_resume1",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h41, 1'b0);
    issue("mi_resume0",   OP_RS, 12'hB02, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    issue("mi_resume1",   OP_RS, 12'hB02, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0);
`else
    issue("mci_wr_ign",   OP_RW, 12'h320, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    issue("mci_rd0",      OP_RS, 12'h320, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    issue("mc_running",   OP_RS, 12'hB00, 5'd0, 32'h0, 1'b0, 32'h2, 1'b0);
    issue("mi_running0",  OP_RS, 12'hB02, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0);
    issue("mi_running1",  OP_RS, 12'hB02, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0);
`endif

    done = 1'b1;
  end

endmodule : tb_csr_write_unit
`default_nettype wire
